lane_ser: RTL and testbench

Multi-lane synchronous parallel-to-serial converter in the serial clock domain, generalising the single-lane latch tree serializer to `LANES` independent lanes of `WIDTH` bits each. It accepts one parallel word per lane per frame through a valid/ready handshake. A one-entry holding register lets the next frame be accepted while the current one shifts out. Outputs are a registered bit stream per lane plus a frame marker. It sits between the per-lane TX data path and the analog driver.

---
 rtl/lane_ser.sv | 98 +++++++++
 tb/tb_lane_ser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_ser.sv
// lane_ser: multi-lane parallel-to-serial converter with a one-entry holding register.
// Define LANE_SER_PRBS_EN to add PRBS7 (x^7+x^6+1) training on idle lanes.
module lane_ser #(
  parameter int   LANES    = 4,
  parameter int   WIDTH    = 32,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   msb_first,
  input  logic                   prbs_en,
  output logic [LANES-1:0]       dout,
  output logic                   frame_start,
  output logic                   busy,
  output logic                   underflow,
  output logic [7:0]             underflow_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                 state;
  logic [LANES*WIDTH-1:0] hold, shreg, load_word, shreg_nx;
  logic [LANES-1:0]       shreg_bits, idle_bits;
  logic [CW-1:0]          cnt;
  logic                   hold_msb, hold_full, last, load, accept, uf_pend, train;
  assign last     = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign load     = hold_full && (state == IDLE || last) && !train;
  assign in_ready = !hold_full || load;
  assign accept   = in_valid && in_ready;
  always_comb begin
    load_word  = hold;
    shreg_nx   = shreg;
    shreg_bits = '0;
    for (int l = 0; l < LANES; l++) begin
      shreg_nx[l*WIDTH +: WIDTH] = shreg[l*WIDTH +: WIDTH] >> 1;
      shreg_bits[l] = shreg[l*WIDTH];
      for (int b = 0; b < WIDTH; b++)
        load_word[l*WIDTH+b] = hold_msb ? hold[l*WIDTH+WIDTH-1-b] : hold[l*WIDTH+b];
    end
  end
`ifdef LANE_SER_PRBS_EN
  logic [6:0] lfsr [LANES];
  assign train = prbs_en;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int l = 0; l < LANES; l++) lfsr[l] <= 7'(l + 1);
    else
      for (int l = 0; l < LANES; l++) lfsr[l] <= {lfsr[l][5:0], lfsr[l][6] ^ lfsr[l][5]};
  always_comb begin
    idle_bits = {LANES{IDLE_VAL}};
    for (int l = 0; l < LANES; l++) idle_bits[l] = prbs_en ? lfsr[l][6] : IDLE_VAL;
  end
`else
  logic unused_prbs;
  assign unused_prbs = prbs_en;
  assign train       = 1'b0;
  assign idle_bits   = {LANES{IDLE_VAL}};
`endif
  // underflow is delayed one cycle so it lines up with the first idle bit on dout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      hold          <= '0;
      hold_msb      <= 1'b0;
      hold_full     <= 1'b0;
      shreg         <= '0;
      cnt           <= '0;
      dout          <= {LANES{IDLE_VAL}};
      frame_start   <= 1'b0;
      busy          <= 1'b0;
      uf_pend       <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (accept) begin
        hold     <= din;
        hold_msb <= msb_first;
      end
      hold_full   <= accept || (hold_full && !load);
      dout        <= state == SHIFT ? shreg_bits : idle_bits;
      frame_start <= state == SHIFT && cnt == '0;
      busy        <= state == SHIFT;
      uf_pend     <= last && !hold_full && !train;
      underflow   <= uf_pend;
      if (uf_pend && underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 8'd1;
      if (load) begin
        shreg <= load_word;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        shreg <= shreg_nx;
        cnt   <= last ? '0 : cnt + 1'b1;
        state <= last ? IDLE : SHIFT;
      end
    end
endmodule

// File: tb/tb_lane_ser.sv
// tb_lane_ser: randomized self-checking bench for lane_ser (LANES=2, WIDTH=8).
module tb_lane_ser;
  logic        clk = 0, rst = 1, in_valid = 0, msb_first = 0, prbs_en = 0;
  logic [15:0] din = '0;
  logic        in_ready, frame_start, busy, underflow;
  logic [1:0]  dout;
  logic [7:0]  underflow_cnt;
  int          n = 0, nf = 0, ucnt = 0;

  lane_ser #(.LANES(2), .WIDTH(8), .IDLE_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .msb_first(msb_first), .prbs_en(prbs_en), .dout(dout), .frame_start(frame_start),
    .busy(busy), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  // Serial bit i of a lane word as it must appear on the wire.
  function automatic logic eb(input logic [7:0] w, input logic m, input int i);
    return m ? w[7-i] : w[i];
  endfunction

  function automatic int sat(input int v);
    return v >= 255 ? 255 : v + 1;
  endfunction

  task automatic test_reset();
    rst = 1;
    #1;
    n++; if (dout !== 2'b00 || frame_start !== 1'b0 || busy !== 1'b0 || underflow !== 1'b0) begin
      nf++; $display("FAIL reset_out dout=%b fs=%b busy=%b uf=%b want 00 0 0 0", dout, frame_start, busy, underflow);
    end
    n++; if (in_ready !== 1'b1 || underflow_cnt !== 8'd0) begin
      nf++; $display("FAIL reset_ready in_ready=%b ucnt=%0d want 1 0", in_ready, underflow_cnt);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    n++; if (dout !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      nf++; $display("FAIL reset_release dout=%b busy=%b rdy=%b want 00 0 1", dout, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    din = 16'hFFFF; msb_first = 0; in_valid = 1;
    @(negedge clk);
    din = 16'hAAAA;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    n++; if (busy !== 1'b1 || in_ready !== 1'b0 || dout !== 2'b11) begin
      nf++; $display("FAIL mid_pre busy=%b rdy=%b dout=%b want 1 0 11", busy, in_ready, dout);
    end
    #2 rst = 1;
    #1;
    n++; if (dout !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || frame_start !== 1'b0 || underflow_cnt !== 8'(ucnt)) begin
      nf++; $display("FAIL mid_async dout=%b busy=%b rdy=%b fs=%b ucnt=%0d want 00 0 1 0 %0d",
                     dout, busy, in_ready, frame_start, underflow_cnt, ucnt);
    end
    @(negedge clk);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      n++; if (busy !== 1'b0 || dout !== 2'b00 || underflow !== 1'b0) begin
        nf++; $display("FAIL mid_after busy=%b dout=%b uf=%b want 0 00 0", busy, dout, underflow);
      end
    end
    din = 16'h0301; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    n++; if (busy !== 1'b0) begin
      nf++; $display("FAIL mid_latency busy=%b want 0", busy);
    end
    @(negedge clk);
    n++; if (busy !== 1'b1 || frame_start !== 1'b1 || dout !== 2'b11) begin
      nf++; $display("FAIL mid_first busy=%b fs=%b dout=%b want 1 1 11", busy, frame_start, dout);
    end
    repeat (8) @(negedge clk);
    ucnt = sat(ucnt);
    n++; if (underflow !== 1'b1 || underflow_cnt !== 8'(ucnt)) begin
      nf++; $display("FAIL mid_uf uf=%b ucnt=%0d want 1 %0d", underflow, underflow_cnt, ucnt);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] w0, w1;
    logic       m;
    logic [1:0] e;
    for (int t = 0; t < 8; t++) begin
      w0 = t == 0 ? 8'hA5 : (t == 1 || t == 2) ? 8'h01 : 8'($urandom);
      w1 = t == 0 ? 8'h3C : 8'($urandom);
      m  = t == 1 ? 1'b1 : t < 3 ? 1'b0 : 1'($urandom);
      din = {w1, w0}; msb_first = m; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      n++; if (busy !== 1'b0 || dout !== 2'b00) begin
        nf++; $display("FAIL single_latency t=%0d busy=%b dout=%b want 0 00", t, busy, dout);
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        e = {eb(w1, m, i), eb(w0, m, i)};
        n++; if (dout !== e || frame_start !== (i == 0) || busy !== 1'b1 || underflow !== 1'b0) begin
          nf++; $display("FAIL single_bit t=%0d i=%0d dout=%b fs=%b busy=%b uf=%b want %b %b 1 0",
                         t, i, dout, frame_start, busy, underflow, e, i == 0);
        end
      end
      @(negedge clk);
      ucnt = sat(ucnt);
      n++; if (dout !== 2'b00 || underflow !== 1'b1 || busy !== 1'b0 || underflow_cnt !== 8'(ucnt)) begin
        nf++; $display("FAIL single_end t=%0d dout=%b uf=%b busy=%b ucnt=%0d want 00 1 0 %0d",
                       t, dout, underflow, busy, underflow_cnt, ucnt);
      end
      @(negedge clk);
      n++; if (underflow !== 1'b0) begin
        nf++; $display("FAIL single_pulse t=%0d uf=%b want 0", t, underflow);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr [4];
    logic        ms [4];
    logic [1:0]  e;
    int          sent, b, f, i;
    logic        acc;
    for (int k = 0; k < 4; k++) begin
      fr[k] = 16'($urandom);
      ms[k] = 1'($urandom);
    end
    sent = 0; din = fr[0]; msb_first = ms[0]; in_valid = 1;
    for (int c = 0; c < 36; c++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      b = c - 2;
      if (b >= 0 && b < 32) begin
        f = b / 8; i = b % 8;
        e = {eb(fr[f][15:8], ms[f], i), eb(fr[f][7:0], ms[f], i)};
        n++; if (dout !== e || frame_start !== (i == 0) || busy !== 1'b1 || underflow !== 1'b0 || underflow_cnt !== 8'(ucnt)) begin
          nf++; $display("FAIL b2b_bit b=%0d dout=%b fs=%b busy=%b uf=%b ucnt=%0d want %b %b 1 0 %0d",
                         b, dout, frame_start, busy, underflow, underflow_cnt, e, i == 0, ucnt);
        end
        if (i >= 1 && i <= 6) begin
          n++; if (in_ready !== (i == 6 || b >= 24)) begin
            nf++; $display("FAIL b2b_ready b=%0d rdy=%b want %b", b, in_ready, i == 6 || b >= 24);
          end
        end
      end else if (b == 32) begin
        ucnt = sat(ucnt);
        n++; if (dout !== 2'b00 || underflow !== 1'b1 || busy !== 1'b0 || underflow_cnt !== 8'(ucnt)) begin
          nf++; $display("FAIL b2b_end dout=%b uf=%b busy=%b ucnt=%0d want 00 1 0 %0d",
                         dout, underflow, busy, underflow_cnt, ucnt);
        end
      end
      if (acc) begin
        sent++;
        if (sent < 4) begin
          din = fr[sent]; msb_first = ms[sent];
        end else in_valid = 0;
      end
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 300; t++) begin
      din = 16'($urandom); msb_first = 1'($urandom); in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (11) @(negedge clk);
      ucnt = sat(ucnt);
      n++; if (underflow_cnt !== 8'(ucnt)) begin
        nf++; $display("FAIL sat_cnt t=%0d ucnt=%0d want %0d", t, underflow_cnt, ucnt);
      end
    end
    n++; if (underflow_cnt !== 8'd255) begin
      nf++; $display("FAIL sat_final ucnt=%0d want 255", underflow_cnt);
    end
  endtask

`ifdef LANE_SER_PRBS_EN
  task automatic test_prbs();
    logic [1:0] s [300];
    int         diff, ones;
    rst = 1; prbs_en = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s[i] = dout;
    end
    diff = 0; ones = 0;
    for (int i = 0; i < 173; i++) begin
      n++; if (s[i][0] !== s[i+127][0]) begin
        nf++; $display("FAIL prbs_period i=%0d got %b want %b", i, s[i+127][0], s[i][0]);
      end
      if (s[i][0] !== s[i][1]) diff++;
      if (i < 127 && s[i][0]) ones++;
    end
    n++; if (diff == 0 || ones != 64) begin
      nf++; $display("FAIL prbs_shape diff=%0d ones=%0d want >0 64", diff, ones);
    end
    din = 16'h5A5A; msb_first = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) begin
      @(negedge clk);
      n++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
        nf++; $display("FAIL prbs_hold busy=%b rdy=%b want 0 0", busy, in_ready);
      end
    end
    prbs_en = 0;
    @(negedge clk);
    n++; if (busy !== 1'b0) begin
      nf++; $display("FAIL prbs_load busy=%b want 0", busy);
    end
    @(negedge clk);
    n++; if (busy !== 1'b1 || frame_start !== 1'b1 || dout !== 2'b00) begin
      nf++; $display("FAIL prbs_first busy=%b fs=%b dout=%b want 1 1 00", busy, frame_start, dout);
    end
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_back_to_back();
    test_saturation();
`ifdef LANE_SER_PRBS_EN
    test_prbs();
`endif
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
